// File: rtl/spu_issue_queue.sv
// spu_issue_queue: dual-issue instruction buffer between fetch and decode.
// Fetch pushes aligned instruction pairs; decode sees the two oldest words
// and retires 0, 1 or 2 of them per cycle. Flush or reset empties the buffer.
module spu_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [PC_W-1:0]          fetch_pc,
  input  logic [31:0]              fetch_inst1,
  input  logic [31:0]              fetch_inst2,
  input  logic                     flush,
  output logic                     issue_valid0,
  output logic [31:0]              issue_inst0,
  output logic [PC_W-1:0]          issue_pc0,
  output logic                     issue_valid1,
  output logic [31:0]              issue_inst1,
  output logic [PC_W-1:0]          issue_pc1,
  input  logic [1:0]               issue_take,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];

  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr_nx1;
  logic [AW-1:0]   wr_ptr_nx1;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_next;
  logic            push;
  logic [1:0]      take_req;
  logic [1:0]      take_eff;
  logic [PC_W-1:0] pc_plus4;

  assign fetch_ready = (count_q <= READY_MAX);
  assign push        = fetch_valid && fetch_ready && !flush;
  assign pc_plus4    = fetch_pc + PC_W'(4);
  assign rd_ptr_nx1  = rd_ptr + AW'(1);
  assign wr_ptr_nx1  = wr_ptr + AW'(1);
  assign count       = count_q;

  // Clamp the requested take to at most 2 words and to what is actually buffered
  always_comb begin
    take_req = (issue_take == 2'd3) ? 2'd2 : issue_take;
    take_eff = take_req;
    if (count_q < CW'(take_req)) begin
      take_eff = count_q[1:0];
    end
    count_next = count_q + (push ? CW'(2) : CW'(0)) - CW'(take_eff);
  end

  // Pointer and occupancy update; reset and flush both empty the buffer
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + AW'(take_eff);
      wr_ptr  <= push ? (wr_ptr + AW'(2)) : wr_ptr;
      count_q <= count_next;
    end
  end

  // Pair storage; contents are don't-care once the pointers are cleared
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr]     <= fetch_inst1;
      pc_mem[wr_ptr]       <= fetch_pc;
      inst_mem[wr_ptr_nx1] <= fetch_inst2;
      pc_mem[wr_ptr_nx1]   <= pc_plus4;
    end
  end

  // Present the two oldest words; invalid slots read as all-zero
  always_comb begin
    issue_valid0 = (count_q >= CW'(1));
    issue_valid1 = (count_q >= CW'(2));
    issue_inst0  = '0;
    issue_pc0    = '0;
    issue_inst1  = '0;
    issue_pc1    = '0;
    if (issue_valid0) begin
      issue_inst0 = inst_mem[rd_ptr];
      issue_pc0   = pc_mem[rd_ptr];
    end
    if (issue_valid1) begin
      issue_inst1 = inst_mem[rd_ptr_nx1];
      issue_pc1   = pc_mem[rd_ptr_nx1];
    end
  end

endmodule

// File: tb/tb_spu_issue_queue.sv
// tb_spu_issue_queue: directed scoreboard bench for spu_issue_queue (DEPTH=8).
module tb_spu_issue_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [10:0] fetch_pc = '0;
  logic [31:0] fetch_inst1 = '0;
  logic [31:0] fetch_inst2 = '0;
  logic        flush = 1'b0;
  logic        issue_valid0;
  logic [31:0] issue_inst0;
  logic [10:0] issue_pc0;
  logic        issue_valid1;
  logic [31:0] issue_inst1;
  logic [10:0] issue_pc1;
  logic [1:0]  issue_take = '0;
  logic [3:0]  count;

  typedef struct {
    int          step;
    logic [3:0]  cnt;
    logic        rdy;
    logic        v0;
    logic [31:0] i0;
    logic [10:0] pc0;
    logic        v1;
    logic [31:0] i1;
    logic [10:0] pc1;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   step_no = 0;

  spu_issue_queue #(.DEPTH(8), .PC_W(11)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_pc     (fetch_pc),
    .fetch_inst1  (fetch_inst1),
    .fetch_inst2  (fetch_inst2),
    .flush        (flush),
    .issue_valid0 (issue_valid0),
    .issue_inst0  (issue_inst0),
    .issue_pc0    (issue_pc0),
    .issue_valid1 (issue_valid1),
    .issue_inst1  (issue_inst1),
    .issue_pc1    (issue_pc1),
    .issue_take   (issue_take),
    .count        (count)
  );

  always #5 clk = ~clk;

  // Instruction word tagged with its own PC so ordering errors are visible
  function automatic logic [31:0] mk(input logic [10:0] pc);
    return {16'hC0DE, 5'd0, pc};
  endfunction

  task automatic cmp(input string name, input int step, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL step %0d %s: got %h, required %h", step, name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("count",  e.step, 32'(count),        32'(e.cnt));
    cmp("ready",  e.step, 32'(fetch_ready),  32'(e.rdy));
    cmp("valid0", e.step, 32'(issue_valid0), 32'(e.v0));
    cmp("inst0",  e.step, issue_inst0,       e.i0);
    cmp("pc0",    e.step, 32'(issue_pc0),    32'(e.pc0));
    cmp("valid1", e.step, 32'(issue_valid1), 32'(e.v1));
    cmp("inst1",  e.step, issue_inst1,       e.i1);
    cmp("pc1",    e.step, 32'(issue_pc1),    32'(e.pc1));
  endtask

  // Drive one cycle of inputs and queue the outputs expected after that edge
  task automatic applyStimulus(input logic fv, input logic [10:0] pc, input logic [1:0] take,
                               input logic fl, input logic rs,
                               input logic [3:0] ecnt, input logic [10:0] epc0, input logic [10:0] epc1);
    exp_t        e;
    logic [10:0] pc2;
    pc2 = pc + 11'd4;
    @(negedge clk);
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_inst1 = mk(pc);
    fetch_inst2 = mk(pc2);
    issue_take  = take;
    flush       = fl;
    reset       = rs;
    @(posedge clk);
    #1;
    step_no++;
    e.step = step_no;
    e.cnt  = ecnt;
    e.rdy  = (ecnt <= 4'd6);
    e.v0   = (ecnt >= 4'd1);
    e.v1   = (ecnt >= 4'd2);
    e.pc0  = e.v0 ? epc0 : 11'd0;
    e.i0   = e.v0 ? mk(epc0) : 32'd0;
    e.pc1  = e.v1 ? epc1 : 11'd0;
    e.i1   = e.v1 ? mk(epc1) : 32'd0;
    sb.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest pending expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    //            fv  pc       take fl rs  cnt  pc0      pc1
    applyStimulus(0, 11'h000, 2'd0, 0, 1, 4'd0, 11'h000, 11'h000); // reset
    applyStimulus(0, 11'h000, 2'd2, 0, 0, 4'd0, 11'h000, 11'h000); // take on empty
    applyStimulus(1, 11'h010, 2'd0, 0, 0, 4'd2, 11'h010, 11'h014); // basic push
    applyStimulus(0, 11'h000, 2'd2, 0, 0, 4'd0, 11'h000, 11'h000); // dual issue
    applyStimulus(1, 11'h100, 2'd0, 0, 0, 4'd2, 11'h100, 11'h104);
    applyStimulus(1, 11'h108, 2'd0, 0, 0, 4'd4, 11'h100, 11'h104);
    applyStimulus(1, 11'h110, 2'd0, 0, 0, 4'd6, 11'h100, 11'h104);
    applyStimulus(1, 11'h118, 2'd0, 0, 0, 4'd8, 11'h100, 11'h104); // full
    applyStimulus(1, 11'h200, 2'd0, 0, 0, 4'd8, 11'h100, 11'h104); // not ready, dropped
    applyStimulus(0, 11'h000, 2'd1, 0, 0, 4'd7, 11'h104, 11'h108); // single pop
    applyStimulus(1, 11'h200, 2'd1, 0, 0, 4'd6, 11'h108, 11'h10C); // count 7: still not ready
    applyStimulus(1, 11'h120, 2'd2, 0, 0, 4'd6, 11'h110, 11'h114); // push+pop together
    applyStimulus(0, 11'h000, 2'd1, 0, 0, 4'd5, 11'h114, 11'h118); // slots straddle 7->0
    applyStimulus(0, 11'h000, 2'd2, 0, 0, 4'd3, 11'h11C, 11'h120);
    applyStimulus(0, 11'h000, 2'd1, 0, 0, 4'd2, 11'h120, 11'h124);
    applyStimulus(0, 11'h000, 2'd1, 0, 0, 4'd1, 11'h124, 11'h000);
    applyStimulus(0, 11'h000, 2'd2, 0, 0, 4'd0, 11'h000, 11'h000); // clamp at count 1
    applyStimulus(1, 11'h300, 2'd0, 0, 0, 4'd2, 11'h300, 11'h304);
    applyStimulus(1, 11'h308, 2'd0, 0, 0, 4'd4, 11'h300, 11'h304);
    applyStimulus(0, 11'h000, 2'd3, 0, 0, 4'd2, 11'h308, 11'h30C); // take 3 acts as 2
    applyStimulus(1, 11'h310, 2'd0, 0, 0, 4'd4, 11'h308, 11'h30C);
    applyStimulus(1, 11'h400, 2'd2, 1, 0, 4'd0, 11'h000, 11'h000); // flush wins
    applyStimulus(1, 11'h7FC, 2'd0, 0, 0, 4'd2, 11'h7FC, 11'h000); // pc+4 wraps
    applyStimulus(1, 11'h020, 2'd0, 0, 0, 4'd4, 11'h7FC, 11'h000);
    applyStimulus(1, 11'h028, 2'd0, 0, 0, 4'd6, 11'h7FC, 11'h000);
    applyStimulus(1, 11'h040, 2'd1, 0, 1, 4'd0, 11'h000, 11'h000); // reset mid-stream
    applyStimulus(1, 11'h050, 2'd0, 0, 0, 4'd2, 11'h050, 11'h054);
    applyStimulus(0, 11'h000, 2'd0, 0, 0, 4'd2, 11'h050, 11'h054); // idle holds
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
